// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory address/data, IR handoff to decode,
// redirect/stall controls and status back to the pipeline.
interface fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 16
);
    logic [ADDR_W-1:0] pc_out;
    logic [INST_W-1:0] inst_in;
    logic [INST_W-1:0] ir_out;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_valid;
    logic              decode_ready;
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              halted;
    logic [15:0]       fetch_cnt;

    modport master (
        output pc_out, ir_out, ir_pc, ir_valid, halted, fetch_cnt,
        input  inst_in, decode_ready, stall, branch_taken, branch_target
    );

    modport slave (
        input  pc_out, ir_out, ir_pc, ir_valid, halted, fetch_cnt,
        output inst_in, decode_ready, stall, branch_taken, branch_target
    );
endinterface

// File: rtl/fetch_unit.sv
// S-Machine instruction fetch: PC, instruction register with valid/ready
// handoff to decode, branch redirect, stall and HALT detection.
module fetch_unit #(
    parameter int              ADDR_W   = 8,
    parameter int              INST_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      HALT_OPC = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_unit_if.master bus
);
    typedef enum logic {ST_FETCH, ST_HALT} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [INST_W-1:0] ir_reg, ir_next;
    logic [ADDR_W-1:0] ir_pc_reg, ir_pc_next;
    logic              ir_valid_reg, ir_valid_next;
    logic [15:0]       cnt_reg, cnt_next;
    logic              halted_comb;

    logic accept, load, is_halt_word;

    assign accept       = ir_valid_reg & bus.decode_ready;
    assign load         = ~ir_valid_reg | bus.decode_ready;
    assign is_halt_word = (bus.inst_in[INST_W-1 -: 4] == HALT_OPC);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: branch overrides everything, stall freezes the FSM
    always_comb begin
        state_next = state_reg;
        if (bus.branch_taken) begin
            state_next = ST_FETCH;
        end else if (!bus.stall && state_reg == ST_FETCH && load && is_halt_word) begin
            state_next = ST_HALT;
        end
    end

    // Output logic
    always_comb begin
        halted_comb = (state_reg == ST_HALT);
    end

    // Datapath next values, same priority order as the FSM
    always_comb begin
        pc_next       = pc_reg;
        ir_next       = ir_reg;
        ir_pc_next    = ir_pc_reg;
        ir_valid_next = ir_valid_reg;
        if (bus.branch_taken) begin
            pc_next       = bus.branch_target;
            ir_valid_next = 1'b0;
        end else if (bus.stall) begin
            if (accept) begin
                ir_valid_next = 1'b0;
            end
        end else if (state_reg == ST_FETCH) begin
            if (load) begin
                ir_next       = bus.inst_in;
                ir_pc_next    = pc_reg;
                ir_valid_next = 1'b1;
                // A HALT word parks the PC on itself
                if (!is_halt_word) begin
                    pc_next = pc_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
        end else begin
            if (accept) begin
                ir_valid_next = 1'b0;
            end
        end
    end

    // Accepted instructions count regardless of branch or stall; saturates
    always_comb begin
        cnt_next = cnt_reg;
        if (accept && cnt_reg != 16'hFFFF) begin
            cnt_next = cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= RESET_PC;
            ir_reg       <= '0;
            ir_pc_reg    <= '0;
            ir_valid_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            pc_reg       <= pc_next;
            ir_reg       <= ir_next;
            ir_pc_reg    <= ir_pc_next;
            ir_valid_reg <= ir_valid_next;
            cnt_reg      <= cnt_next;
        end
    end

    assign bus.pc_out    = pc_reg;
    assign bus.ir_out    = ir_reg;
    assign bus.ir_pc     = ir_pc_reg;
    assign bus.ir_valid  = ir_valid_reg;
    assign bus.halted    = halted_comb;
    assign bus.fetch_cnt = cnt_reg;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_fetch_unit;
    logic clk;
    logic rst_n;
    logic [15:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    fetch_unit_if #(.ADDR_W(8), .INST_W(16)) bus ();

    fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.inst_in = mem[bus.pc_out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: one instruction stream, PC walks memory
    logic [7:0]  m_pc;
    logic [15:0] m_ir;
    logic [7:0]  m_irpc;
    logic        m_valid;
    logic        m_halt;
    logic [15:0] m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    <= 8'h00;
            m_ir    <= 16'h0000;
            m_irpc  <= 8'h00;
            m_valid <= 1'b0;
            m_halt  <= 1'b0;
            m_cnt   <= 16'h0000;
        end else begin
            if (m_valid && bus.decode_ready && m_cnt != 16'hFFFF)
                m_cnt <= m_cnt + 16'd1;
            if (bus.branch_taken) begin
                m_pc    <= bus.branch_target;
                m_valid <= 1'b0;
                m_halt  <= 1'b0;
            end else if (bus.stall) begin
                if (m_valid && bus.decode_ready) m_valid <= 1'b0;
            end else if (m_halt) begin
                if (m_valid && bus.decode_ready) m_valid <= 1'b0;
            end else if (!m_valid || bus.decode_ready) begin
                m_ir    <= mem[m_pc];
                m_irpc  <= m_pc;
                m_valid <= 1'b1;
                if (mem[m_pc][15:12] == 4'hF) m_halt <= 1'b1;
                else                          m_pc   <= m_pc + 8'd1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("pc_out", 32'(bus.pc_out), 32'(m_pc));
            check("ir_valid", 32'(bus.ir_valid), 32'(m_valid));
            check("halted", 32'(bus.halted), 32'(m_halt));
            check("fetch_cnt", 32'(bus.fetch_cnt), 32'(m_cnt));
            if (m_valid) begin
                check("ir_out", 32'(bus.ir_out), 32'(m_ir));
                check("ir_pc", 32'(bus.ir_pc), 32'(m_irpc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset between edges; outputs must clear before any edge
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_pc", 32'(bus.pc_out), 32'h0);
        check("rst_valid", 32'(bus.ir_valid), 32'h0);
        check("rst_cnt", 32'(bus.fetch_cnt), 32'h0);
        check("rst_halted", 32'(bus.halted), 32'h0);
        check("rst_ir", 32'(bus.ir_out), 32'h0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = {4'(($urandom_range(0, 14))), 12'($urandom)};
        mem[0]    = 16'h1111;
        mem[1]    = 16'h2222;
        mem[2]    = 16'h3333;
        mem[3]    = 16'h4444;
        mem[4]    = 16'h5555;
        mem[5]    = 16'hF000;
        mem[8'h40] = 16'h4040;
        rst_n             = 1'b1;
        bus.decode_ready  = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 8'h00;
        #1;
        do_reset();

        // Straight-line fetch at full throughput
        bus.decode_ready = 1'b1;
        tick();
        check("t1_ir0", 32'(bus.ir_out), 32'h1111);
        check("t1_irpc0", 32'(bus.ir_pc), 32'h00);
        check("t1_valid", 32'(bus.ir_valid), 32'h1);
        repeat (3) tick();
        check("t1_ir3", 32'(bus.ir_out), 32'h4444);
        check("t1_irpc3", 32'(bus.ir_pc), 32'h03);
        tick();
        check("t1_cnt", 32'(bus.fetch_cnt), 32'd4);

        // Backpressure holds B in IR
        do_reset();
        tick();
        tick();
        bus.decode_ready = 1'b0;
        repeat (3) tick();
        check("t2_ir_hold", 32'(bus.ir_out), 32'h2222);
        check("t2_pc_hold", 32'(bus.pc_out), 32'h02);
        bus.decode_ready = 1'b1;
        tick();
        check("t2_ir_next", 32'(bus.ir_out), 32'h3333);

        // Stall with accept drains IR but freezes PC; branch beats stall
        bus.stall = 1'b1;
        tick();
        check("t3_pc_st1", 32'(bus.pc_out), 32'h03);
        check("t3_valid_st1", 32'(bus.ir_valid), 32'h0);
        tick();
        check("t3_pc_st2", 32'(bus.pc_out), 32'h03);
        check("t3_ir_st2", 32'(bus.ir_out), 32'h3333);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 8'h40;
        tick();
        check("t3_pc_br", 32'(bus.pc_out), 32'h40);
        check("t3_valid_br", 32'(bus.ir_valid), 32'h0);
        bus.branch_taken = 1'b0;
        bus.stall        = 1'b0;
        tick();
        check("t3_ir_tgt", 32'(bus.ir_out), 32'h4040);
        check("t3_irpc_tgt", 32'(bus.ir_pc), 32'h40);

        // PC wrap FE -> FF -> 00 -> 01
        bus.branch_taken  = 1'b1;
        bus.branch_target = 8'hFE;
        tick();
        bus.branch_taken = 1'b0;
        tick();
        check("t4_irpc_fe", 32'(bus.ir_pc), 32'hFE);
        tick();
        check("t4_irpc_ff", 32'(bus.ir_pc), 32'hFF);
        tick();
        check("t4_irpc_00", 32'(bus.ir_pc), 32'h00);
        check("t4_ir_00", 32'(bus.ir_out), 32'h1111);
        tick();
        check("t4_irpc_01", 32'(bus.ir_pc), 32'h01);

        // HALT word at 5
        bus.decode_ready  = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 8'h05;
        tick();
        bus.branch_taken = 1'b0;
        tick();
        check("t5_halted", 32'(bus.halted), 32'h1);
        check("t5_ir_halt", 32'(bus.ir_out), 32'hF000);
        check("t5_pc_halt", 32'(bus.pc_out), 32'h05);
        tick();
        check("t5_valid_hold", 32'(bus.ir_valid), 32'h1);
        bus.decode_ready = 1'b1;
        tick();
        check("t5_valid_drain", 32'(bus.ir_valid), 32'h0);
        tick();
        check("t5_still_halt", 32'(bus.halted), 32'h1);
        check("t5_no_refetch", 32'(bus.ir_valid), 32'h0);
        check("t5_pc_frozen", 32'(bus.pc_out), 32'h05);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 8'h10;
        tick();
        check("t5_unhalt", 32'(bus.halted), 32'h0);
        check("t5_pc_resume", 32'(bus.pc_out), 32'h10);
        bus.branch_taken = 1'b0;
        tick();
        check("t5_irpc_resume", 32'(bus.ir_pc), 32'h10);

        // Randomized traffic, with a sprinkling of HALT words and resets
        for (int i = 0; i < 10; i++)
            mem[$urandom_range(0, 255)] = {4'hF, 12'($urandom)};
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bus.decode_ready  = ($urandom_range(0, 99) < 70);
            bus.stall         = ($urandom_range(0, 99) < 10);
            bus.branch_taken  = ($urandom_range(0, 99) < 5);
            bus.branch_target = 8'($urandom);
            if ($urandom_range(0, 99) < 2)
                mem[$urandom_range(0, 255)] = 16'($urandom);
            if ($urandom_range(0, 999) < 2)
                do_reset();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
